uart_tx_peripheral: RTL and testbench

Memory-mapped UART transmitter that sits on the data bus as the responder to the load/store unit's UART select (address region 0x8xxx_xxxx). Stores to the TXDATA register push bytes into a small FIFO. An 8N1 serializer drains that FIFO onto the `tx` pin at a programmable baud divisor. Loads return status and divisor with zero-cycle latency, so the pipeline's single-cycle memory stage needs no stall.

---
 rtl/uart_pkg.sv | 35 +++
 rtl/sync_fifo.sv | 67 ++++++
 rtl/uart_tx_peripheral.sv | 199 +++++++++++++++++++
 tb/tb_uart_tx_peripheral.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the memory-mapped UART transmitter.
//   - register offsets (dbus_addr[3:2])
//   - STATUS bit positions
//   - serializer state encoding
//   - minimum baud divisor and its clamp helper
package uart_pkg;

  // Register offsets, decoded from dbus_addr[3:2]
  localparam logic [1:0] UART_TXDATA  = 2'd0;
  localparam logic [1:0] UART_STATUS  = 2'd1;
  localparam logic [1:0] UART_BAUDDIV = 2'd2;
  localparam logic [1:0] UART_RSVD    = 2'd3;

  // STATUS bit positions
  localparam int ST_FULL   = 0;
  localparam int ST_EMPTY  = 1;
  localparam int ST_BUSY   = 2;
  localparam int ST_OVF    = 3;
  localparam int ST_CNT_LO = 4;  // [7:4] saturating FIFO count

  // Smallest divisor the serializer accepts
  localparam logic [15:0] UART_MIN_DIV = 16'd16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  function automatic logic [15:0] clamp_div(input logic [15:0] v);
    return (v < UART_MIN_DIV) ? UART_MIN_DIV : v;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with combinational read data.
//   clk, rst   clock, asynchronous active-high reset (flushes pointers/count)
//   push/wdata write an entry; accepted when not full, or when full and a
//              pop happens in the same cycle
//   pop/rdata  rdata is the head entry; pop is ignored when empty
//   full/empty/count  derived from the count register, not pointer equality
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [AW:0]   CNT_ONE = 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == DEPTH_C);
  assign count   = cnt_q;
  assign rdata   = mem_q[rd_ptr_q];

  assign do_pop  = pop & ~empty;
  // A pop frees the slot this same cycle, so a full FIFO still accepts.
  assign do_push = push & (~full | do_pop);

  always_comb begin
    cnt_d = cnt_q;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: contents are only visible through count.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/uart_tx_peripheral.sv
// uart_tx_peripheral: memory-mapped 8N1 UART transmitter.
//   clk, rst       system clock, asynchronous active-high reset
//   uart_sel, wr   bus access select and store(1)/load(0)
//   dbus_addr      byte address, [3:2] selects TXDATA/STATUS/BAUDDIV/reserved
//   dbus_data_wr   store data; mask = byte-lane enables
//   dbus_data_rd   combinational load data, zero unless a load is selected
//   tx             serial line, idle high
//   tx_busy        serializer active or FIFO holds bytes
module uart_tx_peripheral
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int DEFAULT_DIV = 868
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        uart_sel,
  input  logic        wr,
  input  logic [31:0] dbus_addr,
  input  logic [31:0] dbus_data_wr,
  input  logic [3:0]  mask,
  output logic [31:0] dbus_data_rd,
  output logic        tx,
  output logic        tx_busy
);

  localparam int          CW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [15:0] DEF_DIV = 16'(DEFAULT_DIV);

  // ---------------------------------------------------------------- bus decode
  logic       wr_en, rd_en;
  logic [1:0] reg_sel;
  logic       push, ovf_set, ovf_clr, div_wr;

  assign wr_en   = uart_sel & wr;
  assign rd_en   = uart_sel & ~wr;
  assign reg_sel = dbus_addr[3:2];

  logic unused_bus;
  assign unused_bus = ^{dbus_addr[31:4], dbus_addr[1:0],
                        dbus_data_wr[31:16], mask[3:2]};

  // ---------------------------------------------------------------- FIFO
  logic          fifo_pop, fifo_full, fifo_empty;
  logic [7:0]    fifo_rdata;
  logic [CW-1:0] fifo_count;

  assign push = wr_en && (reg_sel == UART_TXDATA) && mask[0];

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (fifo_pop),
    .wdata (dbus_data_wr[7:0]),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // ---------------------------------------------------------------- registers
  logic        ovf_q, ovf_d;
  logic [15:0] div_q, div_d;

  // Dropped only when full with no pop; a concurrent pop makes room.
  assign ovf_set = push && fifo_full && !fifo_pop;
  assign ovf_clr = wr_en && (reg_sel == UART_STATUS) && mask[0] && dbus_data_wr[3];
  assign div_wr  = wr_en && (reg_sel == UART_BAUDDIV) && (mask[1:0] == 2'b11);

  always_comb begin
    ovf_d = ovf_q;
    if (ovf_set)      ovf_d = 1'b1;   // set beats a same-cycle clear
    else if (ovf_clr) ovf_d = 1'b0;
    div_d = div_wr ? clamp_div(dbus_data_wr[15:0]) : div_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
      div_q <= DEF_DIV;
    end else begin
      ovf_q <= ovf_d;
      div_q <= div_d;
    end
  end

  // ---------------------------------------------------------------- serializer
  uart_state_t state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [15:0] baud_cnt_q, baud_cnt_d;
  logic [15:0] div_lat_q, div_lat_d;
  logic        fifo_seen_q;
  logic        bit_tick;

  assign bit_tick = (state_q != IDLE) && (baud_cnt_q == div_lat_q - 16'd1);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (fifo_pop)                         state_d = START;
      START: if (bit_tick)                         state_d = DATA;
      DATA:  if (bit_tick && bit_cnt_q == 3'd7)    state_d = STOP;
      STOP:  if (bit_tick)                         state_d = IDLE;
      default:                                     state_d = IDLE;
    endcase
  end

  // Outputs. IDLE only starts once the FIFO has been non-empty for a full
  // cycle: a store into an empty FIFO reaches the line two edges later, while
  // a FIFO that stayed non-empty through STOP gives a single IDLE cycle.
  always_comb begin
    tx       = 1'b1;
    fifo_pop = 1'b0;
    case (state_q)
      IDLE:    fifo_pop = fifo_seen_q && !fifo_empty;
      START:   tx = 1'b0;
      DATA:    tx = shift_q[0];
      STOP:    tx = 1'b1;
      default: tx = 1'b1;
    endcase
  end

  // Datapath: shift register, bit/baud counters, per-frame divisor latch
  always_comb begin
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    div_lat_d = div_lat_q;
    if (fifo_pop) begin
      shift_d   = fifo_rdata;
      bit_cnt_d = 3'd0;
      div_lat_d = div_q;
    end else if (state_q == DATA && bit_tick) begin
      shift_d   = {1'b0, shift_q[7:1]};
      bit_cnt_d = bit_cnt_q + 3'd1;
    end
    // Counter restarts on every state entry and on every bit-time wrap.
    if (state_q == IDLE || state_d != state_q || bit_tick) baud_cnt_d = '0;
    else                                                   baud_cnt_d = baud_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      baud_cnt_q  <= '0;
      div_lat_q   <= DEF_DIV;
      fifo_seen_q <= 1'b0;
    end else begin
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      baud_cnt_q  <= baud_cnt_d;
      div_lat_q   <= div_lat_d;
      fifo_seen_q <= ~fifo_empty;
    end
  end

  assign tx_busy = (state_q != IDLE) || !fifo_empty;

  // ---------------------------------------------------------------- load data
  logic [31:0] status;
  logic [31:0] cnt_ext;
  logic [3:0]  cnt_sat;

  assign cnt_ext = 32'(fifo_count);
  assign cnt_sat = (cnt_ext > 32'd15) ? 4'hF : cnt_ext[3:0];

  always_comb begin
    status                          = '0;
    status[ST_FULL]                 = fifo_full;
    status[ST_EMPTY]                = fifo_empty;
    status[ST_BUSY]                 = tx_busy;
    status[ST_OVF]                  = ovf_q;
    status[ST_CNT_LO+3:ST_CNT_LO]   = cnt_sat;
  end

  always_comb begin
    dbus_data_rd = '0;
    if (rd_en) begin
      case (reg_sel)
        UART_STATUS:  dbus_data_rd = status;
        UART_BAUDDIV: dbus_data_rd = {16'h0, div_q};
        default:      dbus_data_rd = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_peripheral.sv
module tb_uart_tx_peripheral;

  localparam logic [31:0] A_TX   = 32'h8000_0000;
  localparam logic [31:0] A_ST   = 32'h8000_0004;
  localparam logic [31:0] A_DIV  = 32'h8000_0008;
  localparam logic [31:0] A_RSV  = 32'h8000_000C;

  logic        clk = 1'b0;
  logic        rst;
  logic        uart_sel, wr;
  logic [31:0] dbus_addr, dbus_data_wr, dbus_data_rd;
  logic [3:0]  mask;
  logic        tx, tx_busy;

  int cyc = 0;
  int total = 0;
  int bad = 0;

  uart_tx_peripheral #(.FIFO_DEPTH(8), .DEFAULT_DIV(868)) dut (
    .clk          (clk),
    .rst          (rst),
    .uart_sel     (uart_sel),
    .wr           (wr),
    .dbus_addr    (dbus_addr),
    .dbus_data_wr (dbus_data_wr),
    .mask         (mask),
    .dbus_data_rd (dbus_data_rd),
    .tx           (tx),
    .tx_busy      (tx_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Advance to 1 time unit after edge number e.
  task automatic goto(input int e);
    while (cyc < e) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Store committed at the next edge; e returns that edge number.
  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] m, output int e);
    uart_sel = 1'b1; wr = 1'b1; dbus_addr = a; dbus_data_wr = d; mask = m;
    @(posedge clk);
    #1;
    e = cyc;
    uart_sel = 1'b0; wr = 1'b0; mask = 4'h0;
  endtask

  task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
    uart_sel = 1'b1; wr = 1'b0; dbus_addr = a;
    #1;
    d = dbus_data_rd;
    uart_sel = 1'b0;
  endtask

  task automatic wait_idle(input int lim, output bit ok);
    int n = 0;
    while (tx_busy && n < lim) begin
      @(posedge clk);
      #1;
      n++;
    end
    ok = !tx_busy;
  endtask

  task automatic test_reset;
    logic [31:0] d;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (tx !== 1'b1) begin bad++; $display("FAIL rst_tx got=%b want=1", tx); end
    total++; if (tx_busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", tx_busy); end
    total++; if (dbus_data_rd !== 32'h0) begin bad++; $display("FAIL rst_rd got=%h want=0", dbus_data_rd); end
    rst = 1'b0;
    @(posedge clk);
    #1;
    bus_rd(A_ST, d);
    total++; if (d !== 32'h0000_0002) begin bad++; $display("FAIL rst_status got=%h want=00000002", d); end
    bus_rd(A_DIV, d);
    total++; if (d !== 32'd868) begin bad++; $display("FAIL rst_div got=%0d want=868", d); end
  endtask

  task automatic test_single_byte;
    int k, s;
    logic [9:0] frame = {1'b1, 8'h55, 1'b0};
    bit errs = 0;
    bus_wr(A_TX, 32'h55, 4'b0001, k);
    goto(k + 1);
    total++; if (tx !== 1'b1) begin bad++; $display("FAIL single_pre_start got=%b want=1", tx); end
    goto(k + 2);
    s = k + 2;
    total++; if (tx !== 1'b0) begin bad++; $display("FAIL single_start_fall got=%b want=0", tx); end
    for (int i = 0; i < 10; i++) begin
      goto(s + i * 868 + 434);
      if (tx !== frame[i]) begin
        errs = 1;
        $display("FAIL single_bit%0d got=%b want=%b", i, tx, frame[i]);
      end
    end
    total++; if (errs) bad++;
    goto(s + 10 * 868 - 1);
    total++; if (tx_busy !== 1'b1) begin bad++; $display("FAIL single_busy_in_stop got=%b want=1", tx_busy); end
    goto(s + 10 * 868 + 1);
    total++; if (tx_busy !== 1'b0) begin bad++; $display("FAIL single_busy_after got=%b want=0", tx_busy); end
    total++; if (tx !== 1'b1) begin bad++; $display("FAIL single_idle_tx got=%b want=1", tx); end
  endtask

  task automatic test_status_read;
    int k0, k1, k2, e;
    logic [31:0] d;
    bit ok;
    bus_wr(A_DIV, 32'd16, 4'b0011, e);
    bus_wr(A_TX, 32'h01, 4'b0001, k0);
    bus_wr(A_TX, 32'h02, 4'b0001, k1);
    bus_wr(A_TX, 32'h03, 4'b0001, k2);
    bus_rd(A_ST, d);
    total++; if (d !== 32'h0000_0024) begin bad++; $display("FAIL status_queued got=%h want=00000024", d); end
    wait_idle(2000, ok);
    total++; if (!ok) begin bad++; $display("FAIL status_drain_timeout busy=%b want=0", tx_busy); end
  endtask

  task automatic test_overflow;
    int k0, e;
    logic [31:0] d;
    bus_wr(A_TX, 32'hC0, 4'b0001, k0);
    for (int i = 1; i < 10; i++) bus_wr(A_TX, 32'hC0 + i, 4'b0001, e);
    bus_rd(A_ST, d);
    total++; if (d !== 32'h0000_008D) begin bad++; $display("FAIL ovf_status got=%h want=0000008d", d); end
    bus_wr(A_ST, 32'h8, 4'b0001, e);
    bus_rd(A_ST, d);
    total++; if (d !== 32'h0000_0085) begin bad++; $display("FAIL ovf_clear got=%h want=00000085", d); end
    // Nine frames of 160 cycles with one IDLE cycle between each.
    goto(k0 + 2 + 8 * 161 + 159);
    total++; if (tx_busy !== 1'b1) begin bad++; $display("FAIL ovf_ninth_frame busy=%b want=1", tx_busy); end
    goto(k0 + 2 + 8 * 161 + 161);
    total++; if (tx_busy !== 1'b0) begin bad++; $display("FAIL ovf_done busy=%b want=0", tx_busy); end
  endtask

  task automatic test_divisor;
    int k, s1, s2, e;
    logic [31:0] d;
    bus_wr(A_TX, 32'hA5, 4'b0001, k);
    bus_wr(A_TX, 32'hFF, 4'b0001, e);
    s1 = k + 2;
    goto(s1 + 15);
    total++; if (tx !== 1'b0) begin bad++; $display("FAIL div_start_end got=%b want=0", tx); end
    goto(s1 + 16);
    total++; if (tx !== 1'b1) begin bad++; $display("FAIL div_bit0 got=%b want=1", tx); end
    goto(s1 + 40);
    bus_wr(A_DIV, 32'd32, 4'b0011, e);
    bus_rd(A_DIV, d);
    total++; if (d !== 32'd32) begin bad++; $display("FAIL div_readback got=%0d want=32", d); end
    goto(s1 + 16 * 6 + 8);
    total++; if (tx !== 1'b1) begin bad++; $display("FAIL div_f1_bit5 got=%b want=1", tx); end
    goto(s1 + 16 * 7 + 8);
    total++; if (tx !== 1'b0) begin bad++; $display("FAIL div_f1_bit6 got=%b want=0", tx); end
    goto(s1 + 160);
    total++; if (tx !== 1'b1) begin bad++; $display("FAIL div_f1_idle got=%b want=1", tx); end
    goto(s1 + 161);
    s2 = s1 + 161;
    total++; if (tx !== 1'b0) begin bad++; $display("FAIL div_f2_start got=%b want=0", tx); end
    goto(s2 + 24);
    total++; if (tx !== 1'b0) begin bad++; $display("FAIL div_f2_start_long got=%b want=0", tx); end
    goto(s2 + 32);
    total++; if (tx !== 1'b1) begin bad++; $display("FAIL div_f2_bit0 got=%b want=1", tx); end
    goto(s2 + 319);
    total++; if (tx_busy !== 1'b1) begin bad++; $display("FAIL div_f2_stop busy=%b want=1", tx_busy); end
    goto(s2 + 321);
    total++; if (tx_busy !== 1'b0) begin bad++; $display("FAIL div_f2_done busy=%b want=0", tx_busy); end
    bus_wr(A_DIV, 32'd5, 4'b0011, e);
    bus_rd(A_DIV, d);
    total++; if (d !== 32'd16) begin bad++; $display("FAIL div_clamp got=%0d want=16", d); end
  endtask

  task automatic test_mask_reserved;
    int e;
    logic [31:0] d;
    bit low = 0;
    bus_wr(A_TX, 32'h41, 4'b0010, e);
    bus_wr(A_RSV, 32'hFFFF_FFFF, 4'b1111, e);
    bus_wr(A_DIV, 32'h40, 4'b0001, e);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (tx !== 1'b1) low = 1;
    end
    total++; if (low) begin bad++; $display("FAIL mask_tx_moved got=low want=high"); end
    bus_rd(A_ST, d);
    total++; if (d !== 32'h0000_0002) begin bad++; $display("FAIL mask_status got=%h want=00000002", d); end
    bus_rd(A_DIV, d);
    total++; if (d !== 32'd16) begin bad++; $display("FAIL mask_div got=%0d want=16", d); end
    bus_rd(A_RSV, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL rsv_read got=%h want=0", d); end
    bus_rd(A_TX, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL txdata_read got=%h want=0", d); end
    uart_sel = 1'b0; wr = 1'b0; dbus_addr = A_ST;
    #1;
    total++; if (dbus_data_rd !== 32'h0) begin bad++; $display("FAIL unsel_read got=%h want=0", dbus_data_rd); end
  endtask

  task automatic test_reset_mid_frame;
    int k, s, e;
    logic [31:0] d;
    bit low = 0;
    bus_wr(A_TX, 32'h00, 4'b0001, k);
    bus_wr(A_TX, 32'h11, 4'b0001, e);
    bus_wr(A_TX, 32'h22, 4'b0001, e);
    s = k + 2;
    goto(s + 16 * 5 + 8);
    total++; if (tx !== 1'b0) begin bad++; $display("FAIL rmid_bit4 got=%b want=0", tx); end
    rst = 1'b1;
    #1;
    total++; if (tx !== 1'b1) begin bad++; $display("FAIL rmid_async_tx got=%b want=1", tx); end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    bus_rd(A_ST, d);
    total++; if (d !== 32'h0000_0002) begin bad++; $display("FAIL rmid_status got=%h want=00000002", d); end
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      if (tx !== 1'b1) low = 1;
    end
    total++; if (low) begin bad++; $display("FAIL rmid_tx_stays got=low want=high"); end
    bus_rd(A_DIV, d);
    total++; if (d !== 32'd868) begin bad++; $display("FAIL rmid_div got=%0d want=868", d); end
  endtask

  initial begin
    uart_sel = 1'b0; wr = 1'b0; dbus_addr = '0; dbus_data_wr = '0; mask = '0;
    rst = 1'b1;
    test_reset();
    test_single_byte();
    test_status_read();
    test_overflow();
    test_divisor();
    test_mask_reserved();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
